// File: rtl/cpu_out_uart_tx.sv
// cpu_out_uart_tx: captures bytes strobed out by the CPU into a small FIFO and
// sends them as 8N1 UART frames on tx (idle high, LSB first, one stop bit).
//
// Handshake: a write is accepted on any rising edge where out_we=1 and the
// registered full flag is 0. There is no back-pressure on the CPU, so a write
// while full is dropped and recorded in the sticky overflow flag.
//
// fsm_state exposes the serialiser state (0=IDLE 1=START 2=DATA 3=STOP) for
// debug and checker binding.
module cpu_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     out_we,
  input  logic [7:0]               out_data,
  input  logic                     ovf_clr,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               last_data,
  output logic [1:0]               fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      last_q, last_d;

  logic            full_w;
  logic            push;
  logic            drop;
  logic            pop;

  // Status flags come straight from registered state so they never glitch.
  assign full_w    = (count_q == DEPTH_C);
  assign push      = out_we & ~full_w;
  assign drop      = out_we & full_w;

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) | (count_q != '0);
  assign full      = full_w;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign last_data = last_q;
  assign fsm_state = state_q;

  // Serialiser next-state: frame timing, bit shifting and the FIFO pop request.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping, overflow flag and display latch next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      last_d   = out_data;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped write wins over a simultaneous clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Serialiser registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // FIFO pointers, occupancy and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= out_data;
    end
  end

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Testbench for cpu_out_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
// A UART receiver process decodes tx and compares each frame against the
// expected-byte queue filled whenever an accepted write is driven.
module tb_cpu_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       out_we   = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       ovf_clr  = 1'b0;
  logic       tx;
  logic       busy;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] last_data;
  logic [1:0] fsm_state;

  cpu_out_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .out_we    (out_we),
    .out_data  (out_data),
    .ovf_clr   (ovf_clr),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .last_data (last_data),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  int         rx_frames = 0;
  logic [7:0] exp_q[$];
  int         fall_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    out_we   = 1'b1;
    out_data = d;
    exp_q.push_back(d);
    tick();
    out_we   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx"},        tx,        1);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_full"},      full,      0);
    check({tag, "_count"},     count,     0);
    check({tag, "_overflow"},  overflow,  0);
    check({tag, "_last_data"}, last_data, 0);
    check({tag, "_fsm"},       fsm_state, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_busy", busy, 0);
  endtask

  // ---------------- UART receiver / scoreboard pop ----------------
  bit         mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = 8'h00;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        fall_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        check("rx_start_bit", tx, 0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
        mon_byte[(mon_cnt - 6) / 4] = tx;
      end else if (mon_cnt == 38) begin
        check("rx_stop_bit", tx, 1);
        rx_frames++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got frame 0x%0h expected no frame", mon_byte);
        end else begin
          check("rx_byte", mon_byte, exp_q.pop_front());
        end
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       we;
    logic [7:0] data;
    logic       clr;
    logic       acc;
    logic [2:0] cnt;
    logic       full;
    logic       ovf;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[9];

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] pat;
    int         base_frames;
    int         low_seen;

    // Table: six writes on consecutive edges into an idle block, then the
    // overflow clear corner. The first edge after the first push also pops.
    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h01};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h02};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h03};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h04};
    vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'h05};
    vecs[5] = '{1'b1, 8'h06, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h05};
    vecs[6] = '{1'b1, 8'h07, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 8'h05};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 8'h05};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'h05};

    // Power-on reset.
    repeat (3) tick();
    check_reset_vals("por");
    #2 reset = 1'b1;
    repeat (2) tick();

    // Single byte 0xA5 from idle: tx low one cycle after the push edge,
    // then the exact 10-slot bit pattern.
    push_byte(8'hA5);
    check("a5_tx_after_push", tx, 1);
    check("a5_busy_after_push", busy, 1);
    tick();
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      check($sformatf("a5_slot%0d_c%0d", i / CPB, i % CPB), tx, pat[i / CPB]);
      if (i == 10 * CPB - 1) check("a5_busy_last", busy, 1);
      tick();
    end
    check("a5_busy_done", busy, 0);
    check("a5_tx_done", tx, 1);
    repeat (3) tick();
    check("a5_frames", rx_frames, 1);

    // Reset pulse mid-frame after a write, then confirm nothing resumes.
    push_byte(8'h5A);
    repeat ($urandom_range(12, 8)) tick();
    check("mid_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("mid");
    exp_q.delete();
    repeat (2) tick();
    #2 reset = 1'b1;
    base_frames = rx_frames;
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) low_seen++;
    end
    check("mid_no_resume_low", low_seen, 0);
    check("mid_no_resume_frames", rx_frames, base_frames);

    // Table-driven burst: overflow, full, last_data and the clear corner.
    fall_q.delete();
    base_frames = rx_frames;
    for (int i = 0; i < 9; i++) begin
      out_we   = vecs[i].we;
      out_data = vecs[i].data;
      ovf_clr  = vecs[i].clr;
      if (vecs[i].acc) exp_q.push_back(vecs[i].data);
      tick();
      check($sformatf("vec%0d_count", i),     count,     vecs[i].cnt);
      check($sformatf("vec%0d_full", i),      full,      vecs[i].full);
      check($sformatf("vec%0d_overflow", i),  overflow,  vecs[i].ovf);
      check($sformatf("vec%0d_last_data", i), last_data, vecs[i].last);
      check($sformatf("vec%0d_busy", i),      busy,      1);
    end
    out_we  = 1'b0;
    ovf_clr = 1'b0;
    wait_idle(400);
    repeat (3) tick();
    check("burst_frames", rx_frames - base_frames, 5);
    check("burst_queue_empty", exp_q.size(), 0);
    check("burst_falls", fall_q.size(), 5);
    if (fall_q.size() >= 3) begin
      check("spacing_0_1", fall_q[1] - fall_q[0], 10 * CPB + 1);
      check("spacing_1_2", fall_q[2] - fall_q[1], 10 * CPB + 1);
    end else begin
      checks++;
      errors++;
      $display("FAIL spacing: got %0d start edges expected at least 3", fall_q.size());
    end

    // Reset during DATA bit 3 of 0x3C with two more bytes queued.
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    check("rst5_count_queued", count, 2);
    repeat (17) tick();
    check("rst5_in_data", fsm_state, 2);
    check("rst5_tx_bit3", tx, 1);
    #2 reset = 1'b0;
    #1;
    check("rst5_tx", tx, 1);
    check("rst5_count", count, 0);
    check("rst5_busy", busy, 0);
    exp_q.delete();
    tick();
    #2 reset = 1'b1;
    base_frames = rx_frames;
    low_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1) low_seen++;
    end
    check("rst5_no_frames_low", low_seen, 0);
    check("rst5_no_frames", rx_frames, base_frames);
    check("rst5_idle_count", count, 0);
    check("rst5_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
